// File: rtl/spi_slave_param_if.sv
// Pin and RAM-side bundle for spi_slave_param.
// The slave modport is the DUT view, and the master modport is the pin/RAM driver view.
interface spi_slave_param_if #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
);
    localparam int RX_W = CMD_W + DATA_W;

    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic [RX_W-1:0]   rx_data;
    logic              rx_valid;
    logic              MISO;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output rx_data, rx_valid, MISO, busy, frame_err
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  rx_data, rx_valid, MISO, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parameterised SPI slave: deserialises {cmd, payload} frames and serialises read data on MISO.
// It tracks a read-address phase so that alternate read frames return data.
module spi_slave_param #(
    parameter int DATA_W    = 8,
    parameter int CMD_W     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_slave_param_if.slave    bus
);
    localparam int RX_W  = CMD_W + DATA_W;
    localparam int RXC_W = $clog2(RX_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [RXC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RX_W-1:0]   shift_q, shift_d;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q, miso_d;
    logic              rd_addr_flag_q, rd_addr_flag_d;

    logic [RX_W-1:0]   shift_in;
    logic [DATA_W-1:0] tx_next;
    logic              last_bit;

    always_comb begin
        shift_in = '0;
        tx_next  = '0;
        if (MSB_FIRST != 0) begin
            shift_in = {shift_q[RX_W-2:0], bus.MOSI};
            tx_next  = tx_shift_q << 1;
        end else begin
            shift_in = {bus.MOSI, shift_q[RX_W-1:1]};
            tx_next  = tx_shift_q >> 1;
        end
        last_bit = (bit_cnt_q == RXC_W'(RX_W - 1));
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = '0;
        tx_cnt_d       = '0;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        tx_shift_d     = tx_shift_q;
        rx_valid_d     = 1'b0;
        frame_err_d    = 1'b0;
        miso_d         = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;

        case (state_q)
            IDLE: begin
                if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (!bus.MOSI) begin
                    state_d = WRITE;
                end else if (rd_addr_flag_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                // A frame whose last bit lands together with SS_n rising still completes
                if (last_bit) begin
                    shift_d    = shift_in;
                    rx_data_d  = shift_in;
                    rx_valid_d = 1'b1;
                    if (state_q == READ_DATA) begin
                        state_d = WAIT_TX;
                    end else begin
                        state_d = HOLD;
                        if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
                    end
                end else if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            WAIT_TX: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (bus.tx_valid) begin
                    tx_shift_d = bus.tx_data;
                    miso_d     = (MSB_FIRST != 0) ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (tx_cnt_q == TXC_W'(DATA_W - 1)) begin
                    rd_addr_flag_d = 1'b0;
                    state_d        = HOLD;
                end else begin
                    tx_shift_d = tx_next;
                    miso_d     = (MSB_FIRST != 0) ? tx_next[DATA_W-1] : tx_next[0];
                    tx_cnt_d   = tx_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            tx_cnt_q       <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            tx_shift_q     <= '0;
            rx_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            tx_shift_q     <= tx_shift_d;
            rx_valid_q     <= rx_valid_d;
            frame_err_q    <= frame_err_d;
            miso_q         <= miso_d;
            rd_addr_flag_q <= rd_addr_flag_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.MISO      = miso_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
